// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-master arbiter for a single-port data memory with starvation
//            limit and bounded locked bursts for the secondary master.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int c_WAIT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int c_BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [c_WAIT_W-1:0]  c_STARVE_MAX = c_WAIT_W'(STARVE_LIMIT);
  localparam logic [c_BURST_W-1:0] c_BURST_MAX  = c_BURST_W'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_WAIT_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic [c_BURST_W-1:0]  r_burst_cnt, w_burst_nxt;
  logic                  w_gnt0, w_gnt1, w_m1_wins;

  always_comb begin
    w_m1_wins   = ((r_state == ST_OWN1) && m1_lock && (r_burst_cnt < c_BURST_MAX)) ||
                  (r_wait_cnt == c_STARVE_MAX);
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = ST_IDLE;
    w_wait_nxt  = '0;
    w_burst_nxt = '0;

    // Grants are gated by reset so nothing reaches memory while rst_n is low.
    if (rst_n) begin
      if (m0_req && m1_req) begin
        w_gnt1 = w_m1_wins;
        w_gnt0 = !w_m1_wins;
      end else begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req;
      end
    end

    if (w_gnt0)      w_state_nxt = ST_OWN0;
    else if (w_gnt1) w_state_nxt = ST_OWN1;

    if (m1_req && !w_gnt1)
      w_wait_nxt = (r_wait_cnt < c_STARVE_MAX) ? r_wait_cnt + 1'b1 : r_wait_cnt;

    // Burst count only survives while m1 keeps a locked ownership going.
    if (w_gnt1 && m1_lock) begin
      if (m0_req && (r_burst_cnt < c_BURST_MAX)) w_burst_nxt = r_burst_cnt + 1'b1;
      else                                       w_burst_nxt = r_burst_cnt;
    end
  end

  always_comb begin
    m0_gnt    = w_gnt0;
    m1_gnt    = w_gnt1;
    mem_read  = (w_gnt0 && !m0_we) || (w_gnt1 && !m1_we);
    mem_write = (w_gnt0 && m0_we)  || (w_gnt1 && m1_we);
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt0) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (w_gnt1) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= w_gnt0 && !m0_we;
      m1_rvalid <= w_gnt1 && !m1_we;
      if (w_gnt0 && !m0_we) m0_rdata <= mem_rdata;
      if (w_gnt1 && !m1_we) m1_rdata <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed and randomized checks of dmem_arbiter against a rule model.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

  localparam int MAXB = 4;
  localparam int STV  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_BURST(MAXB), .STARVE_LIMIT(STV)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory behind the arbiter: 16 words, combinational read.
  logic [31:0] tbmem [16];
  logic        preload;

  function automatic logic [31:0] init_word(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) tbmem[i] <= init_word(i);
    end else if (mem_write) begin
      tbmem[mem_addr[5:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = tbmem[mem_addr[5:2]];

  // Reference model state
  logic [31:0] mm [16];
  int          owner;      // 0 none, 1 m0, 2 m1
  int          waited, burst, obs_wait;
  logic [31:0] exp_rd0, exp_rd1;
  bit          last_g0, last_g1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = 0; waited = 0; burst = 0; obs_wait = 0;
    exp_rd0 = '0; exp_rd1 = '0;
  endtask

  // One clock cycle: called and returns 1 time unit after a rising edge.
  task automatic cyc(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                     input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                     input bit lk, input bit rst_mid);
    bit          g0, g1, p0, p1;
    logic [31:0] n0, n1, ea, ed;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = lk;
    #1;
    if (r0 && r1) begin
      g1 = (owner == 2 && lk && burst < MAXB) || (waited == STV);
      g0 = !g1;
    end else begin
      g0 = r0; g1 = r1;
    end
    ea = g0 ? a0 : (g1 ? a1 : 32'h0);
    ed = g0 ? d0 : (g1 ? d1 : 32'h0);
    check("m0_gnt", 32'(m0_gnt), 32'(g0));
    check("m1_gnt", 32'(m1_gnt), 32'(g1));
    check("mem_write", 32'(mem_write), 32'((g0 && w0) || (g1 && w1)));
    check("mem_read", 32'(mem_read), 32'((g0 && !w0) || (g1 && !w1)));
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, ed);
    last_g0 = m0_gnt; last_g1 = m1_gnt;
    if (m1_req && !m1_gnt) obs_wait++;
    else                   obs_wait = 0;
    check("starve_bound", 32'(obs_wait <= STV), 32'h1);

    if (rst_mid) begin
      rst_n = 1'b0;
      #1;
      check("rst_gnt0", 32'(m0_gnt), 32'h0);
      check("rst_mem_wr", 32'(mem_write), 32'h0);
      model_reset();
      @(posedge clk); #1;
      check("rst_rvalid0", 32'(m0_rvalid), 32'h0);
      check("rst_rdata0", m0_rdata, 32'h0);
      check("rst_rvalid1", 32'(m1_rvalid), 32'h0);
      rst_n = 1'b1;
      return;
    end

    p0 = g0 && !w0; p1 = g1 && !w1;
    n0 = mm[a0[5:2]]; n1 = mm[a1[5:2]];
    if (g0 && w0) mm[a0[5:2]] = d0;
    if (g1 && w1) mm[a1[5:2]] = d1;
    waited = (!r1 || g1) ? 0 : ((waited < STV) ? waited + 1 : waited);
    if (g1 && lk) burst = (r0 && burst < MAXB) ? burst + 1 : burst;
    else          burst = 0;
    owner = g0 ? 1 : (g1 ? 2 : 0);

    @(posedge clk); #1;
    if (p0) exp_rd0 = n0;
    if (p1) exp_rd1 = n1;
    check("m0_rvalid", 32'(m0_rvalid), 32'(p0));
    check("m1_rvalid", 32'(m1_rvalid), 32'(p1));
    check("m0_rdata", m0_rdata, exp_rd0);
    check("m1_rdata", m1_rdata, exp_rd1);
  endtask

  initial begin
    int cnt1, cnt0, first;
    rst_n = 1'b0; preload = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
    for (int i = 0; i < 16; i++) mm[i] = init_word(i);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt0", 32'(m0_gnt), 32'h0);
    check("reset_gnt1", 32'(m1_gnt), 32'h0);
    check("reset_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'h0);
    check("reset_rdata0", m0_rdata, 32'h0);
    check("reset_memwr", 32'(mem_write), 32'h0);
    preload = 1'b0;
    rst_n   = 1'b1;

    // Write then read back on m0
    cyc(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 32'h10, 32'h0,        0, 0, 0, 0, 0, 0);
    check("t1_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1_rvalid", 32'(m0_rvalid), 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Both requesting, no lock: m1 gets the 9th and 18th slot
    cnt1 = 0; first = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 32'(i % 16) << 2, 0, 1, 0, 32'((i + 3) % 16) << 2, 0, 0, 0);
      if (last_g1) begin
        cnt1++;
        if (first < 0) first = i;
      end
    end
    check("t2_m1_first", 32'(first), 32'd8);
    check("t2_m1_count", 32'(cnt1), 32'd2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Locked m1 owner, then m0 contends: exactly MAXB more m1 grants
    cyc(0, 0, 0, 0, 1, 1, 32'h20, 32'h1111_0000, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'h20, 32'h0,         1, 0);
    cnt1 = 0; first = -1;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 32'h4, 0, 1, 1, 32'(i) << 2, 32'h5500 + 32'(i), 1, 0);
      if (first < 0 && last_g0) first = i;
      if (first < 0 && last_g1) cnt1++;
    end
    check("t3_locked_grants", 32'(cnt1), 32'd4);
    check("t3_m0_after", 32'(first), 32'd4);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Uncontended locked burst of 10 reads
    cnt1 = 0; cnt0 = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 32'(i) * 4, 0, 1, 0);
      cnt1 += int'(last_g1);
      cnt0 += int'(last_g0);
    end
    check("t4_m1_grants", 32'(cnt1), 32'd10);
    check("t4_m0_grants", 32'(cnt0), 32'd0);

    // Reset between a read grant and its return
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 32'h10, 0, 1, 0, 32'h8, 0, 1, 0);
    check("t5_resume_m0", 32'(last_g0), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      cyc(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
          32'($urandom_range(0, 15)) << 2, $urandom,
          bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
          32'($urandom_range(0, 15)) << 2, $urandom,
          bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 999) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
